// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU select codes, instruction field
// positions and the operand-fetch output bundle.
package cpu_pkg;

  localparam int REG_N = 8;
  localparam int REG_W = 8;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 24;
  localparam int RD_HI  = 18;
  localparam int RD_LO  = 16;
  localparam int RT_HI  = 10;
  localparam int RT_LO  = 8;
  localparam int RS_HI  = 2;
  localparam int RS_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    SEL_FWD  = 3'b000,
    SEL_ADD  = 3'b001,
    SEL_AND  = 3'b010,
    SEL_OR   = 3'b011,
    SEL_RSVD = 3'b100
  } alu_sel_e;

  typedef struct packed {
    logic [7:0] data1;
    logic [7:0] data2;
    alu_sel_e   sel;
    logic [2:0] dest;
    logic       we;
    logic       br;
    logic       jmp;
    logic       ill;
  } of_bundle_t;

  function automatic logic [7:0] neg8(input logic [7:0] v);
    return ~v + 8'd1;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 8x8 register file: two combinational read ports, one write port,
// synchronous active-high reset.
module reg_file
  import cpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_rt_addr,
  input  logic [2:0]       i_rs_addr,
  input  logic             i_wr_en,
  input  logic [2:0]       i_wr_addr,
  input  logic [REG_W-1:0] i_wr_data,
  output logic [REG_W-1:0] o_rt_data,
  output logic [REG_W-1:0] o_rs_data
);

  logic [REG_W-1:0] r_mem [REG_N];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rt_data = r_mem[i_rt_addr];
  assign o_rs_data = r_mem[i_rs_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decode, register read, registered valid/ready output.
// Define REG_BYPASS_EN to forward same-cycle write-back data to the reads.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        WB_EN,
  input  logic [2:0]  WB_ADDR,
  input  logic [7:0]  WB_DATA,
  output logic [7:0]  DATA1,
  output logic [7:0]  DATA2,
  output logic [2:0]  SELECT,
  output logic [2:0]  DEST,
  output logic        WRITE_EN,
  output logic        BRANCH,
  output logic        JUMP,
  output logic        ILLEGAL,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e     r_state;
  of_bundle_t r_out;
  of_bundle_t w_dec;

  logic [7:0] w_op;
  logic [2:0] w_rd;
  logic [2:0] w_rt;
  logic [2:0] w_rs;
  logic [7:0] w_imm;
  logic [7:0] w_rf_rt;
  logic [7:0] w_rf_rs;
  logic [7:0] w_rt_val;
  logic [7:0] w_rs_val;
  logic       w_accept;
  logic       w_unused;

  assign w_op  = INSTRUCTION[OP_HI:OP_LO];
  assign w_rd  = INSTRUCTION[RD_HI:RD_LO];
  assign w_rt  = INSTRUCTION[RT_HI:RT_LO];
  assign w_rs  = INSTRUCTION[RS_HI:RS_LO];
  assign w_imm = INSTRUCTION[IMM_HI:IMM_LO];
  assign w_unused = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  reg_file u_rf (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_rt_addr (w_rt),
    .i_rs_addr (w_rs),
    .i_wr_en   (WB_EN),
    .i_wr_addr (WB_ADDR),
    .i_wr_data (WB_DATA),
    .o_rt_data (w_rf_rt),
    .o_rs_data (w_rf_rs)
  );

`ifdef REG_BYPASS_EN
  assign w_rt_val = (WB_EN && WB_ADDR == w_rt) ? WB_DATA : w_rf_rt;
  assign w_rs_val = (WB_EN && WB_ADDR == w_rs) ? WB_DATA : w_rf_rs;
`else
  assign w_rt_val = w_rf_rt;
  assign w_rs_val = w_rf_rs;
`endif

  always_comb begin
    w_dec      = '0;
    w_dec.dest = w_rd;
    w_dec.sel  = SEL_FWD;
    unique case (w_op)
      OP_LOADI: begin
        w_dec.data2 = w_imm;
        w_dec.we    = 1'b1;
      end
      OP_MOV: begin
        w_dec.data2 = w_rs_val;
        w_dec.we    = 1'b1;
      end
      OP_ADD, OP_AND, OP_OR: begin
        w_dec.data1 = w_rt_val;
        w_dec.data2 = w_rs_val;
        w_dec.we    = 1'b1;
        w_dec.sel   = (w_op == OP_ADD) ? SEL_ADD :
                      (w_op == OP_AND) ? SEL_AND : SEL_OR;
      end
      OP_SUB, OP_BEQ: begin
        w_dec.data1 = w_rt_val;
        w_dec.data2 = neg8(w_rs_val);
        w_dec.sel   = SEL_ADD;
        w_dec.we    = (w_op == OP_SUB);
        w_dec.br    = (w_op == OP_BEQ);
      end
      OP_J: begin
        w_dec.data2 = w_imm;
        w_dec.jmp   = 1'b1;
      end
      default: begin
        w_dec.ill = 1'b1;
        w_dec.sel = SEL_RSVD;
      end
    endcase
  end

  assign IN_READY = (r_state == S_EMPTY) || OUT_READY;
  assign w_accept = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_EMPTY;
      r_out   <= '0;
    end else if (w_accept) begin
      r_state <= S_FULL;
      r_out   <= w_dec;
    end else if (OUT_READY) begin
      r_state <= S_EMPTY;
    end
  end

  assign OUT_VALID = (r_state == S_FULL);
  assign DATA1     = r_out.data1;
  assign DATA2     = r_out.data2;
  assign SELECT    = r_out.sel;
  assign DEST      = r_out.dest;
  assign WRITE_EN  = r_out.we;
  assign BRANCH    = r_out.br;
  assign JUMP      = r_out.jmp;
  assign ILLEGAL   = r_out.ill;

endmodule
